branch_resolve_bht: RTL

Parametrised branch resolution unit with a bimodal branch history table (BHT). It sits at the execute-stage boundary and evaluates MIPS conditional branches and jumps on DATA_W-bit operands. It compares the outcome against the fetch-time prediction, raises a registered mispredict pulse and squashes the following SQUASH_CYCLES resolve slots. It also serves same-cycle taken/not-taken predictions to fetch from a table of saturating counters and keeps saturating branch and mispredict statistics.

---
 rtl/branch_resolve_bht.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/branch_resolve_bht.sv
// Execute-stage branch resolution with a bimodal history table.
// Resolves MIPS branches/jumps, flags mispredicts and squashes the following slots.
module branch_resolve_bht #(
    parameter int DATA_W        = 32,
    parameter int BHT_ENTRIES   = 64,
    parameter int CTR_W         = 2,
    parameter int SQUASH_CYCLES = 2,
    parameter int STAT_W        = 16
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic [31:0]       lookup_pc,
    output logic              predict_taken,
    input  logic              res_valid,
    input  logic [31:0]       res_pc,
    input  logic [31:0]       res_instr,
    input  logic [DATA_W-1:0] res_opa,
    input  logic [DATA_W-1:0] res_opb,
    input  logic              res_jump,
    input  logic              res_pred_taken,
    output logic              out_valid,
    output logic              out_taken,
    output logic              out_is_jp_branch,
    output logic              out_mispredict,
    output logic [STAT_W-1:0] br_count,
    output logic [STAT_W-1:0] mp_count
);

    localparam int IDX_W = $clog2(BHT_ENTRIES);
    localparam int SQ_W  = (SQUASH_CYCLES < 2) ? 1 : $clog2(SQUASH_CYCLES + 1);
    localparam logic [CTR_W-1:0] CTR_INIT = CTR_W'((1 << (CTR_W - 1)) - 1);

    typedef enum logic {ST_RUN, ST_SQUASH} state_t;

    state_t            state_q, state_d;
    logic [SQ_W-1:0]   sq_cnt_q, sq_cnt_d;
    logic              out_valid_q, out_valid_d;
    logic              out_taken_q, out_taken_d;
    logic              out_jp_q, out_jp_d;
    logic              out_mp_q, out_mp_d;
    logic [STAT_W-1:0] br_count_q, br_count_d;
    logic [STAT_W-1:0] mp_count_q, mp_count_d;
    logic [CTR_W-1:0]  bht_q [BHT_ENTRIES];
    logic [CTR_W-1:0]  bht_wdata_d;
    logic              bht_we_d;

    logic [5:0]        opcode;
    logic [4:0]        rt;
    logic [IDX_W-1:0]  upd_idx;
    logic [CTR_W-1:0]  upd_ctr;
    logic              is_branch, br_taken, taken, is_jp, mispredict, accept;
    logic              opa_neg, opa_zero;
    logic              unused_bits;

    assign opcode   = res_instr[31:26];
    assign rt       = res_instr[20:16];
    assign opa_neg  = res_opa[DATA_W-1];
    assign opa_zero = (res_opa == '0);
    assign upd_idx  = res_pc[IDX_W+1:2];
    assign upd_ctr  = bht_q[upd_idx];

    assign predict_taken = bht_q[lookup_pc[IDX_W+1:2]][CTR_W-1];

    assign unused_bits = ^{lookup_pc[31:IDX_W+2], lookup_pc[1:0],
                           res_pc[31:IDX_W+2], res_pc[1:0],
                           res_instr[25:21], res_instr[15:0]};

    always_comb begin
        is_branch = 1'b0;
        br_taken  = 1'b0;
        case (opcode)
            6'b000001: begin
                is_branch = 1'b1;
                case (rt)
                    5'b00000, 5'b10000: br_taken = opa_neg;
                    5'b00001, 5'b10001: br_taken = ~opa_neg;
                    default:            br_taken = 1'b0;
                endcase
            end
            6'b000100: begin
                is_branch = 1'b1;
                br_taken  = (res_opa == res_opb);
            end
            6'b000101: begin
                is_branch = 1'b1;
                br_taken  = (res_opa != res_opb);
            end
            6'b000110: begin
                is_branch = 1'b1;
                br_taken  = opa_neg | opa_zero;
            end
            6'b000111: begin
                is_branch = 1'b1;
                br_taken  = ~opa_neg & ~opa_zero;
            end
            default: ;
        endcase
    end

    assign taken      = br_taken | res_jump;
    assign is_jp      = is_branch | res_jump;
    assign mispredict = is_jp & (taken != res_pred_taken);
    assign accept     = res_valid & (state_q == ST_RUN);

    always_comb begin
        state_d  = state_q;
        sq_cnt_d = sq_cnt_q;
        case (state_q)
            ST_RUN: begin
                if (accept && mispredict && (SQUASH_CYCLES > 0)) begin
                    state_d  = ST_SQUASH;
                    sq_cnt_d = SQ_W'(SQUASH_CYCLES);
                end
            end
            ST_SQUASH: begin
                sq_cnt_d = sq_cnt_q - SQ_W'(1);
                if (sq_cnt_q <= SQ_W'(1)) begin
                    state_d = ST_RUN;
                end
            end
            default: state_d = ST_RUN;
        endcase
    end

    always_comb begin
        out_valid_d = accept;
        out_taken_d = accept & taken;
        out_jp_d    = accept & is_jp;
        out_mp_d    = accept & mispredict;
        br_count_d  = br_count_q;
        mp_count_d  = mp_count_q;
        if (accept && is_jp && (br_count_q != '1)) begin
            br_count_d = br_count_q + STAT_W'(1);
        end
        if (accept && mispredict && (mp_count_q != '1)) begin
            mp_count_d = mp_count_q + STAT_W'(1);
        end
    end

    // Jumps are unconditional and would only pollute the direction counters.
    always_comb begin
        bht_we_d    = accept & is_branch & ~res_jump;
        bht_wdata_d = upd_ctr;
        if (br_taken) begin
            if (upd_ctr != '1) bht_wdata_d = upd_ctr + CTR_W'(1);
        end else begin
            if (upd_ctr != '0) bht_wdata_d = upd_ctr - CTR_W'(1);
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q     <= ST_RUN;
            sq_cnt_q    <= '0;
            out_valid_q <= 1'b0;
            out_taken_q <= 1'b0;
            out_jp_q    <= 1'b0;
            out_mp_q    <= 1'b0;
            br_count_q  <= '0;
            mp_count_q  <= '0;
        end else begin
            state_q     <= state_d;
            sq_cnt_q    <= sq_cnt_d;
            out_valid_q <= out_valid_d;
            out_taken_q <= out_taken_d;
            out_jp_q    <= out_jp_d;
            out_mp_q    <= out_mp_d;
            br_count_q  <= br_count_d;
            mp_count_q  <= mp_count_d;
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            for (int i = 0; i < BHT_ENTRIES; i++) begin
                bht_q[i] <= CTR_INIT;
            end
        end else if (bht_we_d) begin
            bht_q[upd_idx] <= bht_wdata_d;
        end
    end

    assign out_valid        = out_valid_q;
    assign out_taken        = out_taken_q;
    assign out_is_jp_branch = out_jp_q;
    assign out_mispredict   = out_mp_q;
    assign br_count         = br_count_q;
    assign mp_count         = mp_count_q;

endmodule
